// File: rtl/multicycle_control.sv
// multicycle_control: main control FSM for a multicycle RV32I-style datapath.
// Each instruction is sequenced as fetch, decode and then a short opcode-specific
// tail. A wait counter bounds memory stalls in the fetch, load and store states;
// a stall that reaches TIMEOUT (when non-zero) parks the FSM in a sticky TRAP
// state that only rst_n can leave.
// Optional feature: define UTYPE_EN to execute lui/auipc through a UTYPE state;
// without it both opcodes are treated as illegal and trap.
module multicycle_control #(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       adrsrc,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic [1:0] resultsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [2:0] immsrc,
  output logic       trap
);

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JLINK    = 4'd12,
    S_TRAP     = 4'd13
`ifdef UTYPE_EN
    , S_UTYPE  = 4'd14
`endif
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wait_st_s;
  logic             timeout_s;
  logic             unused_funct3;

  // Only bit 0 of funct3 selects the branch sense.
  assign unused_funct3 = ^funct3[2:1];

  // The memory-wait states are the only ones that may stall.
  assign wait_st_s = (state_q == S_FETCH) || (state_q == S_MEMREAD) ||
                     (state_q == S_MEMWRITE);

  // A stall has used up its budget when the counter reaches TIMEOUT.
  assign timeout_s = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

  // State and wait-counter registers; reset parks the FSM in FETCH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Wait counter: counts stalled cycles, clears whenever the state moves.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && wait_st_s && !mem_ready) begin
      if (cnt_q == {CNT_W{1'b1}}) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1'b1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Immediate format follows the opcode in every state.
  always_comb begin
    immsrc = 3'b000;
    case (op)
      OP_LW, OP_I, OP_JALR: immsrc = 3'b000;
      OP_SW:                immsrc = 3'b001;
      OP_B:                 immsrc = 3'b010;
      OP_JAL:               immsrc = 3'b011;
      OP_LUI, OP_AUIPC:     immsrc = 3'b100;
      default:              immsrc = 3'b000;
    endcase
  end

  // Next-state and control-output decode from the current state.
  always_comb begin
    state_d   = state_q;
    pcwrite   = 1'b0;
    adrsrc    = 1'b0;
    memwrite  = 1'b0;
    irwrite   = 1'b0;
    regwrite  = 1'b0;
    resultsrc = 2'b00;
    alusrca   = 2'b00;
    alusrcb   = 2'b00;
    aluop     = 2'b00;
    trap      = 1'b0;
    case (state_q)
      S_FETCH: begin
        // PC+4 goes through the ALU and straight back to the PC.
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        irwrite   = mem_ready;
        pcwrite   = mem_ready;
        if (mem_ready) begin
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        // Precompute oldPC+imm so branch/jal targets sit in ALUOut.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_B:         state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
          OP_JALR:      state_d = S_JALR;
`ifdef UTYPE_EN
          OP_LUI, OP_AUIPC: state_d = S_UTYPE;
`endif
          default:      state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        if (op == OP_LW) begin
          state_d = S_MEMREAD;
        end else if (op == OP_SW) begin
          state_d = S_MEMWRITE;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) begin
          state_d = S_MEMWB;
        end else if (timeout_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_MEMREAD;
        end
      end
      S_MEMWB: begin
        resultsrc = 2'b01;
        regwrite  = 1'b1;
        state_d   = S_FETCH;
      end
      S_MEMWRITE: begin
        // The write strobe is held for the whole access, including the ready cycle.
        adrsrc   = 1'b1;
        memwrite = 1'b1;
        if (mem_ready) begin
          state_d = S_FETCH;
        end else if (timeout_s) begin
          state_d = S_TRAP;
        end else begin
          state_d = S_MEMWRITE;
        end
      end
      S_EXECR: begin
        alusrca = 2'b10;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        alusrca = 2'b10;
        alusrcb = 2'b01;
        aluop   = 2'b10;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        // Compare rs1-rs2; the target already waits in ALUOut.
        alusrca = 2'b10;
        aluop   = 2'b01;
        pcwrite = zero ^ funct3[0];
        state_d = S_FETCH;
      end
      S_JAL: begin
        // Jump to ALUOut while computing the link value oldPC+4.
        alusrca = 2'b01;
        alusrcb = 2'b10;
        pcwrite = 1'b1;
        state_d = S_ALUWB;
      end
      S_JALR: begin
        // rs1+imm goes straight to the PC.
        alusrca   = 2'b10;
        alusrcb   = 2'b01;
        resultsrc = 2'b10;
        pcwrite   = 1'b1;
        state_d   = S_JLINK;
      end
      S_JLINK: begin
        alusrca = 2'b01;
        alusrcb = 2'b10;
        state_d = S_ALUWB;
      end
`ifdef UTYPE_EN
      S_UTYPE: begin
        // lui adds the immediate to zero, auipc adds it to oldPC.
        alusrcb = 2'b01;
        if (op == OP_LUI) begin
          alusrca = 2'b11;
        end else begin
          alusrca = 2'b01;
        end
        state_d = S_ALUWB;
      end
`endif
      S_TRAP: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
      default: begin
        trap    = 1'b1;
        state_d = S_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table vectors, hand-written corner sequences and a
// randomized run checked against a step-list reference model.
// Honours UTYPE_EN the same way the design does.
module tb_multicycle_control;

  localparam int TB_TIMEOUT = 4;
  localparam int TB_CNT_W   = 4;

  localparam logic [6:0] LW    = 7'b0000011;
  localparam logic [6:0] SW    = 7'b0100011;
  localparam logic [6:0] RT    = 7'b0110011;
  localparam logic [6:0] IT    = 7'b0010011;
  localparam logic [6:0] BR    = 7'b1100011;
  localparam logic [6:0] JAL   = 7'b1101111;
  localparam logic [6:0] JALR  = 7'b1100111;
  localparam logic [6:0] LUI   = 7'b0110111;
  localparam logic [6:0] AUIPC = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       zero;
  logic       mem_ready;
  logic       pcwrite, adrsrc, memwrite, irwrite, regwrite, trap;
  logic [1:0] resultsrc, alusrca, alusrcb, aluop;
  logic [2:0] immsrc;
  logic [16:0] obs;

  multicycle_control #(.TIMEOUT(TB_TIMEOUT), .CNT_W(TB_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .zero(zero),
    .mem_ready(mem_ready), .pcwrite(pcwrite), .adrsrc(adrsrc),
    .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .resultsrc(resultsrc), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .immsrc(immsrc), .trap(trap)
  );

  always #5 clk = ~clk;

  // bit 16 pcwrite .. bit 12 regwrite, 11:10 resultsrc, 9:8 alusrca,
  // 7:6 alusrcb, 5:4 aluop, 3:1 immsrc, 0 trap
  assign obs = {pcwrite, adrsrc, memwrite, irwrite, regwrite, resultsrc,
                alusrca, alusrcb, aluop, immsrc, trap};

  int n_pass = 0;
  int n_total = 0;
  logic [16:0] got_w, exp_w;

  typedef struct packed {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        z;
    logic        mr;
    logic [16:0] exp;
  } vec_t;
  vec_t vecs[$];

  function automatic logic [16:0] cw(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] ao, input logic [2:0] imm,
                                     input logic tr);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, ao, imm, tr};
  endfunction

  function automatic void add(input logic [6:0] o, input logic [2:0] f, input logic z,
                              input logic mr, input logic [16:0] e);
    vec_t v;
    v.op = o; v.f3 = f; v.z = z; v.mr = mr; v.exp = e;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [16:0] got, input logic [16:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %05h expected %05h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  // The current step is a name; decode expands the opcode into the list of
  // steps still to run, and the instruction ends when that list is empty.
  string m_cur;
  string m_plan[$];
  int    m_wait;

  function automatic void model_reset();
    m_cur = "FETCH";
    m_plan.delete();
    m_wait = 0;
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == LW || o == IT || o == JALR) return 3'b000;
    if (o == SW) return 3'b001;
    if (o == BR) return 3'b010;
    if (o == JAL) return 3'b011;
    if (o == LUI || o == AUIPC) return 3'b100;
    return 3'b000;
  endfunction

  function automatic void plan_for(input logic [6:0] o);
    m_plan.delete();
    if (o == LW) begin
      m_plan.push_back("MEMADR"); m_plan.push_back("MEMREAD"); m_plan.push_back("MEMWB");
    end else if (o == SW) begin
      m_plan.push_back("MEMADR"); m_plan.push_back("MEMWRITE");
    end else if (o == RT) begin
      m_plan.push_back("EXECR"); m_plan.push_back("ALUWB");
    end else if (o == IT) begin
      m_plan.push_back("EXECI"); m_plan.push_back("ALUWB");
    end else if (o == BR) begin
      m_plan.push_back("BRANCH");
    end else if (o == JAL) begin
      m_plan.push_back("JAL"); m_plan.push_back("ALUWB");
    end else if (o == JALR) begin
      m_plan.push_back("JALR"); m_plan.push_back("JLINK"); m_plan.push_back("ALUWB");
`ifdef UTYPE_EN
    end else if (o == LUI || o == AUIPC) begin
      m_plan.push_back("UTYPE"); m_plan.push_back("ALUWB");
`endif
    end else begin
      m_plan.push_back("TRAP");
    end
  endfunction

  function automatic logic [16:0] model_out(input logic [6:0] o, input logic [2:0] f,
                                            input logic z, input logic mr);
    logic [2:0] im;
    im = imm_of(o);
    if (m_cur == "FETCH")    return cw(mr, 1'b0, 1'b0, mr, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00, im, 1'b0);
    if (m_cur == "DECODE")   return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00, im, 1'b0);
    if (m_cur == "MEMADR")   return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00, im, 1'b0);
    if (m_cur == "MEMREAD")  return cw(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0);
    if (m_cur == "MEMWB")    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00, im, 1'b0);
    if (m_cur == "MEMWRITE") return cw(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0);
    if (m_cur == "EXECR")    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10, im, 1'b0);
    if (m_cur == "EXECI")    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10, im, 1'b0);
    if (m_cur == "ALUWB")    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b0);
    if (m_cur == "BRANCH")   return cw(z ^ f[0], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, im, 1'b0);
    if (m_cur == "JAL")      return cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, im, 1'b0);
    if (m_cur == "JALR")     return cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b10, 2'b01, 2'b00, im, 1'b0);
    if (m_cur == "JLINK")    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00, im, 1'b0);
    if (m_cur == "UTYPE")    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00,
                                       (o == LUI) ? 2'b11 : 2'b01, 2'b01, 2'b00, im, 1'b0);
    return cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, im, 1'b1);
  endfunction

  function automatic void model_step(input logic [6:0] o, input logic mr);
    bit waits;
    waits = (m_cur == "FETCH") || (m_cur == "MEMREAD") || (m_cur == "MEMWRITE");
    if (m_cur == "TRAP") return;
    if (waits && !mr) begin
      if (TB_TIMEOUT != 0 && m_wait == TB_TIMEOUT) begin
        m_cur = "TRAP";
        m_wait = 0;
      end else begin
        m_wait++;
      end
      return;
    end
    m_wait = 0;
    if (m_cur == "FETCH") begin
      m_cur = "DECODE";
    end else begin
      if (m_cur == "DECODE") plan_for(o);
      if (m_plan.size() == 0) m_cur = "FETCH";
      else m_cur = m_plan.pop_front();
    end
  endfunction

  // ---------------- stimulus helpers ----------------
  // Called just after a rising edge: drive, sample on the falling edge, advance.
  task automatic tick(input logic [6:0] o, input logic [2:0] f, input logic z, input logic mr);
    op = o; funct3 = f; zero = z; mem_ready = mr;
    @(negedge clk);
    got_w = obs;
    exp_w = model_out(o, f, z, mr);
    model_step(o, mr);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    mem_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  int mw_cycles;
  int r;
  logic [6:0] cur_op;
  logic [6:0] ops [10];

  initial begin
    ops = '{LW, SW, RT, IT, BR, JAL, JALR, LUI, AUIPC, LW};
    rst_n = 1'b1; op = LW; funct3 = 3'b000; zero = 1'b0; mem_ready = 1'b0;
    cur_op = LW;

    // Table: lw, beq, bne, R-type, I-type, jal, jalr with memory always ready.
    add(LW, 3'd0, 1'b0, 1'b1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add(LW, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add(LW, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0));
    add(LW, 3'd0, 1'b0, 1'b1, cw(0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    add(LW, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));
    add(BR, 3'd0, 1'b1, 1'b1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0));
    add(BR, 3'd0, 1'b1, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
    add(BR, 3'd0, 1'b1, 1'b1, cw(1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0));
    add(BR, 3'd1, 1'b1, 1'b1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b010,0));
    add(BR, 3'd1, 1'b1, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b010,0));
    add(BR, 3'd1, 1'b1, 1'b1, cw(0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,3'b010,0));
    add(RT, 3'd0, 1'b0, 1'b1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add(RT, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add(RT, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000,0));
    add(RT, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    add(IT, 3'd0, 1'b0, 1'b1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add(IT, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add(IT, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,3'b000,0));
    add(IT, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));
    add(JAL, 3'd0, 1'b0, 1'b1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b011,0));
    add(JAL, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b011,0));
    add(JAL, 3'd0, 1'b0, 1'b1, cw(1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b011,0));
    add(JAL, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b011,0));
    add(JALR, 3'd0, 1'b0, 1'b1, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    add(JALR, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0));
    add(JALR, 3'd0, 1'b0, 1'b1, cw(1,0,0,0,0,2'b10,2'b10,2'b01,2'b00,3'b000,0));
    add(JALR, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,0,2'b00,2'b01,2'b10,2'b00,3'b000,0));
    add(JALR, 3'd0, 1'b0, 1'b1, cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,0));

    // Reset state: FETCH outputs, gated by mem_ready.
    #1 rst_n = 1'b0;
    #1 check("reset_mr0", obs, cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    mem_ready = 1'b1;
    #1 check("reset_mr1", obs, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));
    mem_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].mr);
      check($sformatf("vec%0d", i), got_w, vecs[i].exp);
    end

    // sw with three stalled cycles: memwrite held for four cycles, no trap.
    reset_dut();
    mw_cycles = 0;
    tick(SW, 3'd0, 1'b0, 1'b1); check("sw_fetch", got_w, exp_w);
    tick(SW, 3'd0, 1'b0, 1'b1); check("sw_decode", got_w, exp_w);
    tick(SW, 3'd0, 1'b0, 1'b1); check("sw_memadr", got_w, exp_w);
    for (int k = 0; k < 4; k++) begin
      tick(SW, 3'd0, 1'b0, (k == 3));
      check($sformatf("sw_wait%0d", k), got_w, exp_w);
      if (got_w[14]) mw_cycles++;
    end
    check("sw_mw_cycles", 17'(mw_cycles), 17'd4);
    tick(SW, 3'd0, 1'b0, 1'b0);
    check("sw_back_fetch", got_w, cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b001,0));

    // lw stalling exactly TIMEOUT cycles, ready on the limit cycle: completes.
    reset_dut();
    tick(LW, 3'd0, 1'b0, 1'b1); check("lwto_fetch", got_w, exp_w);
    tick(LW, 3'd0, 1'b0, 1'b1); check("lwto_decode", got_w, exp_w);
    tick(LW, 3'd0, 1'b0, 1'b1); check("lwto_memadr", got_w, exp_w);
    for (int k = 0; k < TB_TIMEOUT; k++) begin
      tick(LW, 3'd0, 1'b0, 1'b0); check($sformatf("lwto_wait%0d", k), got_w, exp_w);
    end
    tick(LW, 3'd0, 1'b0, 1'b1); check("lwto_ready", got_w, exp_w);
    tick(LW, 3'd0, 1'b0, 1'b1);
    check("lwto_memwb", got_w, cw(0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,0));

    // FETCH starved: TRAP after TIMEOUT+1 cycles, sticky until reset.
    reset_dut();
    for (int k = 0; k < TB_TIMEOUT + 1; k++) begin
      tick(LW, 3'd0, 1'b0, 1'b0); check($sformatf("fto_fetch%0d", k), got_w, exp_w);
    end
    for (int k = 0; k < 3; k++) begin
      tick(LW, 3'd0, 1'b1, 1'b1);
      check($sformatf("fto_trap%0d", k), got_w, cw(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1));
    end
    reset_dut();
    tick(LW, 3'd0, 1'b0, 1'b0);
    check("fto_after_reset", got_w, cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0));

    // lui / auipc.
    reset_dut();
    tick(LUI, 3'd0, 1'b0, 1'b1);
    check("lui_fetch", got_w, cw(1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,3'b100,0));
    tick(LUI, 3'd0, 1'b0, 1'b1); check("lui_decode", got_w, exp_w);
    tick(LUI, 3'd0, 1'b0, 1'b1);
`ifdef UTYPE_EN
    check("lui_utype", got_w, cw(0,0,0,0,0,2'b00,2'b11,2'b01,2'b00,3'b100,0));
    tick(LUI, 3'd0, 1'b0, 1'b1);
    check("lui_aluwb", got_w, cw(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b100,0));
    tick(AUIPC, 3'd0, 1'b0, 1'b1); check("auipc_fetch", got_w, exp_w);
    tick(AUIPC, 3'd0, 1'b0, 1'b1); check("auipc_decode", got_w, exp_w);
    tick(AUIPC, 3'd0, 1'b0, 1'b1);
    check("auipc_utype", got_w, cw(0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b100,0));
`else
    check("lui_trap", got_w, cw(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b100,1));
`endif

    // Reset in the middle of MEMWRITE drops memwrite at once.
    reset_dut();
    tick(SW, 3'd0, 1'b0, 1'b1); check("rmw_fetch", got_w, exp_w);
    tick(SW, 3'd0, 1'b0, 1'b1); check("rmw_decode", got_w, exp_w);
    tick(SW, 3'd0, 1'b0, 1'b1); check("rmw_memadr", got_w, exp_w);
    tick(SW, 3'd0, 1'b0, 1'b0); check("rmw_memwrite", got_w, exp_w);
    #2 check("rmw_mw_before", 17'(memwrite), 17'd1);
    rst_n = 1'b0;
    #1 check("rmw_async", obs, cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b001,0));
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick(SW, 3'd0, 1'b0, 1'b0);
      check($sformatf("rmw_after%0d", k), got_w, cw(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b001,0));
    end

    // Randomized run against the model; traps are cleared with a reset.
    reset_dut();
    for (int i = 0; i < 1500; i++) begin
      if (m_cur == "TRAP") begin
        tick(cur_op, 3'd0, 1'b0, 1'b1);
        check($sformatf("rand_trap%0d", i), got_w, exp_w);
        reset_dut();
      end else begin
        if (m_cur == "FETCH") begin
          r = $urandom_range(0, 11);
          if (r < 10) cur_op = ops[r];
          else cur_op = 7'($urandom_range(0, 127));
        end
        tick(cur_op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) != 0));
        check($sformatf("rand%0d", i), got_w, exp_w);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 15, meaning the memory-wait cycle limit (0 disables the limit).
REQ-002 The block SHALL have parameter CNT_W, default 4, meaning the wait-counter width; the value SHALL be at least clog2(TIMEOUT+1).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port op, input, 7 bits: the opcode of the instruction register.
REQ-006 The block SHALL have port funct3, input, 3 bits: branch condition select (bit 0: 0=beq, 1=bne).
REQ-007 The block SHALL have port zero, input, 1 bit: the ALU zero flag.
REQ-008 The block SHALL have port mem_ready, input, 1 bit: memory access complete this cycle.
REQ-009 The block SHALL have outputs pcwrite, adrsrc, memwrite, irwrite and regwrite, each 1 bit.
REQ-010 The block SHALL have outputs resultsrc, alusrca, alusrcb and aluop, each 2 bits.
REQ-011 The block SHALL have output immsrc, 3 bits: I=000, S=001, B=010, J=011, U=100.
REQ-012 The block SHALL have output trap, 1 bit: sticky fault indication.

Function
REQ-013 The block SHALL implement states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, JLINK and TRAP, plus UTYPE when the macro is defined.
REQ-014 All outputs SHALL be decoded from state, gated only by mem_ready, zero and funct3; unlisted outputs SHALL be 0.
REQ-015 immsrc SHALL be decoded combinationally from op in every state: lw/I-type/jalr=I, sw=S, branch=B, jal=J, lui/auipc=U, else 000.
REQ-016 FETCH: adrsrc=0, alusrca=00, alusrcb=10, resultsrc=10; irwrite=pcwrite=mem_ready; go to DECODE on mem_ready, else hold.
REQ-017 DECODE: alusrca=01, alusrcb=01 (branch/jal target into ALUOut).
REQ-018 DECODE next state SHALL be: lw/sw to MEMADR, R-type to EXECR, I-type to EXECI, branch to BRANCH, jal to JAL, jalr to JALR, U-type to UTYPE, otherwise TRAP.
REQ-019 MEMADR: alusrca=10, alusrcb=01; go to MEMREAD for lw, MEMWRITE for sw.
REQ-020 MEMREAD: adrsrc=1, resultsrc=00; hold until mem_ready, then MEMWB.
REQ-021 MEMWB: resultsrc=01, regwrite=1, then FETCH.
REQ-022 MEMWRITE: adrsrc=1, resultsrc=00; memwrite=1 while waiting; go to FETCH on mem_ready.
REQ-023 EXECR (alusrca=10, alusrcb=00, aluop=10) and EXECI (alusrca=10, alusrcb=01, aluop=10) SHALL go to ALUWB.
REQ-024 ALUWB: resultsrc=00, regwrite=1, then FETCH.
REQ-025 BRANCH: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, pcwrite=zero XOR funct3[0]; then FETCH.
REQ-026 JAL: alusrca=01, alusrcb=10, resultsrc=00, pcwrite=1, then ALUWB (link = oldPC+4).
REQ-027 JALR: alusrca=10, alusrcb=01, resultsrc=10, pcwrite=1, then JLINK.
REQ-028 JLINK: alusrca=01, alusrcb=10, then ALUWB.
REQ-029 The wait counter SHALL increment each cycle in FETCH, MEMREAD or MEMWRITE while mem_ready=0, and clear on any state change.
REQ-030 When TIMEOUT!=0 and the counter equals TIMEOUT while mem_ready=0, the next state SHALL be TRAP.
REQ-031 If mem_ready=1 in that same cycle, the access SHALL complete normally.
REQ-032 TRAP: all control outputs 0, trap=1; TRAP SHALL be left only by reset.

Reset
REQ-033 On rst_n=0, asynchronously: state=FETCH, counter=0, trap=0, and the FETCH outputs with mem_ready gating.
REQ-034 Reset asserted mid-instruction SHALL abandon the instruction; no regwrite or memwrite SHALL occur after deassertion before a new FETCH completes.

Configuration
REQ-035 With UTYPE_EN defined, lui (0110111) and auipc (0010111) SHALL go DECODE to UTYPE to ALUWB.
REQ-036 UTYPE: alusrcb=01, aluop=00, alusrca=11 (zero) for lui, 01 (oldPC) for auipc.
REQ-037 Without UTYPE_EN, both opcodes SHALL be illegal and go to TRAP.

Verification
REQ-038 lw, mem_ready=1 always -> FETCH,DECODE,MEMADR,MEMREAD,MEMWB; regwrite=1 only in the 5th cycle with resultsrc=01.
REQ-039 beq with zero=1, then bne with zero=1 -> pcwrite=1 in BRANCH for beq, 0 for bne; 3 cycles each.
REQ-040 sw with mem_ready low for 3 cycles, TIMEOUT=15 -> memwrite=1 for 4 cycles, then FETCH, trap=0.
REQ-041 FETCH with mem_ready held 0, TIMEOUT=4 -> TRAP after 5 cycles; trap stays 1 until rst_n pulse, then FETCH.
REQ-042 op=0110111 -> UTYPE, ALUWB with alusrca=11 when UTYPE_EN is defined; trap=1 after DECODE when it is not.
REQ-043 rst_n pulsed low during MEMWRITE -> memwrite drops immediately (asynchronous), state=FETCH.
